seq_div_unit: RTL and testbench
===============================

// Module: seq_div_unit
// PURPOSE
//   Multi-cycle signed 32-bit divider serving the ALU DIV opcode. It sits between the
//   bus/Y operand sources and the 64-bit Z register.
//   Quotient drives ZLO and remainder drives ZHI; the control step loads Z only after done.
//   Radix-2 restoring algorithm: one quotient bit per clock.
// PARAMETERS
//   WIDTH   32   operand/result width in bits (even, >=4)
// PORTS
//   clk          in   1      system clock, all state changes on rising edge
//   clr          in   1      synchronous active-high reset
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  signed dividend (from Y), latched at accepting edge
//   divisor      in   WIDTH  signed divisor (from bus), latched at accepting edge
//   busy         out  1      high in every state except IDLE
//   done         out  1      one-cycle pulse: quotient/remainder valid
//   div_by_zero  out  1      set with done when divisor==0; held with results
//   quotient     out  WIDTH  signed quotient (-> ZLO)
//   remainder    out  WIDTH  signed remainder (-> ZHI)
// BEHAVIOUR
//   Reset: synchronous, active-high, on clk rising edge.
//   - clr=1 at an edge: state->IDLE; busy, done, div_by_zero=0; quotient, remainder=0;
//     internal counter and accumulators cleared.
//   - clr overrides start and any in-flight operation. Aborted op produces no done.
//   FSM states: IDLE, SETUP, ITER, FIX, DONE.
//   - IDLE: start=1 -> latch operands.
//     - divisor!=0 -> SETUP.
//     - divisor==0 -> DONE; same edge loads quotient={WIDTH{1}}, remainder=dividend,
//       div_by_zero=1.
//   - SETUP: form |dividend|, |divisor|; record signs; clear partial remainder;
//     count=0 -> ITER.
//   - ITER: shift {rem,dvd} left 1; trial = rem - |divisor|.
//     - trial >= 0: rem=trial, q bit=1; else q bit=0.
//     - count increments each edge; after WIDTH iterations (count==WIDTH-1 at edge) -> FIX.
//   - FIX: quotient negated if signs differ; remainder takes dividend sign.
//     Register outputs, div_by_zero=0 -> DONE.
//   - DONE: done=1 for this one cycle -> IDLE next edge.
//   Latency: done high WIDTH+3 edges after the start-sampling edge (35 for WIDTH=32);
//     1 edge for divide-by-zero.
//   Results/div_by_zero hold stable from DONE until the next accepted start or clr.
//   start while busy (incl. DONE) ignored, not queued; operand changes while busy ignored.
//   Arithmetic:
//     - quotient truncates toward zero; remainder sign = dividend sign;
//       |remainder| < |divisor|.
//     - Abs/negate in WIDTH+1 bits internally.
//     - MIN_INT / -1 -> quotient=MIN_INT (wraps), remainder=0, no flag.
//     - MIN_INT / 1 -> quotient=MIN_INT, remainder=0.
//     - dividend 0 -> quotient 0, remainder 0.
// TESTING
//   1 0x0000FF0F / 0x00000F0F -> done at edge 35; q=0x00000010, r=0x00000E1F, dbz=0.
//   2 -100 / 7 -> q=0xFFFFFFF2, r=0xFFFFFFFE; 100 / -7 -> q=0xFFFFFFF2, r=0x00000002.
//   3 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dbz=0; 0 / 5 -> q=0, r=0.
//   4 0x00000005 / 0 -> done 1 edge after start; q=0xFFFFFFFF, r=5, dbz=1;
//     dbz clears on next valid op.
//   5 start pulsed again at edge 10 of 100/7 with new operands -> ignored;
//     single done at edge 35, q=14, r=2.
//   6 clr at ITER edge 12 -> next edge: busy=0, q=r=0, no done;
//     fresh 0x62/0x12 -> q=5, r=0x08.

Source files
------------

// File: rtl/seq_div_unit.sv
// Multi-cycle signed restoring divider (radix-2, one quotient bit per clock).
// Quotient feeds ZLO, remainder feeds ZHI; results hold until the next accepted start.
module seq_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opa_nxt;
    logic [WIDTH-1:0] opb, opb_nxt;
    logic [WIDTH-1:0] dvs_abs, dvs_abs_nxt;
    logic [WIDTH-1:0] dvd_sh, dvd_sh_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             trial_ge;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            opa         <= '0;
            opb         <= '0;
            dvs_abs     <= '0;
            dvd_sh      <= '0;
            rem         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_nxt;
            opa         <= opa_nxt;
            opb         <= opb_nxt;
            dvs_abs     <= dvs_abs_nxt;
            dvd_sh      <= dvd_sh_nxt;
            rem         <= rem_nxt;
            count       <= count_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
        end
    end

    // Next-state, iteration step and output values
    always_comb begin
        state_nxt     = state;
        opa_nxt       = opa;
        opb_nxt       = opb;
        dvs_abs_nxt   = dvs_abs;
        dvd_sh_nxt    = dvd_sh;
        rem_nxt       = rem;
        count_nxt     = count;
        dbz_nxt       = div_by_zero;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;

        // Partial remainder stays below |divisor|, so the shifted value fits WIDTH+1 bits
        shifted  = {rem, dvd_sh[WIDTH-1]};
        trial_ge = shifted >= {1'b0, dvs_abs};
        trial    = shifted[WIDTH-1:0] - dvs_abs;

        case (state)
            IDLE: begin
                if (start) begin
                    opa_nxt = dividend;
                    opb_nxt = divisor;
                    if (divisor == '0) begin
                        quotient_nxt  = '1;
                        remainder_nxt = dividend;
                        dbz_nxt       = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                // Magnitudes are unsigned, so |MIN_INT| is representable in WIDTH bits
                dvd_sh_nxt  = opa[WIDTH-1] ? WIDTH'(-opa) : opa;
                dvs_abs_nxt = opb[WIDTH-1] ? WIDTH'(-opb) : opb;
                rem_nxt     = '0;
                count_nxt   = '0;
                state_nxt   = ITER;
            end
            ITER: begin
                rem_nxt    = trial_ge ? trial : shifted[WIDTH-1:0];
                dvd_sh_nxt = {dvd_sh[WIDTH-2:0], trial_ge};
                count_nxt  = CW'(count + 1'b1);
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                quotient_nxt  = (opa[WIDTH-1] ^ opb[WIDTH-1]) ? WIDTH'(-dvd_sh) : dvd_sh;
                remainder_nxt = opa[WIDTH-1] ? WIDTH'(-rem) : rem;
                dbz_nxt       = 1'b0;
                state_nxt     = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: directed vector table, multi-cycle corner
// sequences and randomized operands against a plain-arithmetic reference model.
module tb_seq_div_unit;

    localparam int unsigned W = 32;
    localparam int          MAX_WAIT = 60;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: language division truncates toward zero, remainder follows dividend
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '1; r = a; dbz = 1'b1; lat = 1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); dbz = 1'b0; lat = W + 3;
        end
    endtask

    // Launch one op; lat = edges from the start-sampling edge (counted as 1) to done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dbz, output int lat);
        @(posedge clk); #1;
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient; r = remainder; dbz = div_by_zero;
    endtask

    vec_t         vecs[$];
    logic [W-1:0] q, r, eq, er;
    logic         dbz, edbz;
    int           lat, elat, ndone, done_edge;

    initial begin
        clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_busy", W'(busy), 0);
        chk("reset_done", W'(done), 0);
        chk("reset_dbz", W'(div_by_zero), 0);
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        clr = 1'b0;

        vecs.push_back('{32'h0000FF0F, 32'h00000F0F, 32'h00000010, 32'h00000E1F, 1'b0, 35});
        vecs.push_back('{32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 35});
        vecs.push_back('{32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0, 35});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 35});
        vecs.push_back('{32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 35});
        vecs.push_back('{32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 1'b1, 1});
        vecs.push_back('{32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 35});
        vecs.push_back('{32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0, 35});
        vecs.push_back('{32'h00000003, 32'h00000007, 32'h00000000, 32'h00000003, 1'b0, 35});
        vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 35});

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dbz, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), W'(dbz), W'(vecs[i].dbz));
            chk($sformatf("vec%0d_lat", i), W'(lat), W'(vecs[i].lat));
        end

        // done is a single pulse; results and flag hold afterwards (last vector set dbz=0)
        @(posedge clk); #1;
        chk("done_pulse_low", W'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", quotient, 32'h00000000);
        chk("hold_r", remainder, 32'h7FFFFFFF);
        chk("hold_busy", W'(busy), 0);

        // dbz then a valid op: flag clears
        run_op(32'h00000009, 32'h00000000, q, r, dbz, lat);
        chk("dbz_set", W'(dbz), 1);
        run_op(32'h00000009, 32'h00000002, q, r, dbz, lat);
        chk("dbz_clear", W'(dbz), 0);
        chk("dbz_clear_q", q, 32'h00000004);

        // Second start while busy is ignored
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        ndone = 0; done_edge = 0;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                start = 1'b0;
                chk("ign_busy", W'(busy), 1);
            end
            if (e == 9) begin
                dividend = 32'd50; divisor = 32'd3; start = 1'b1;
            end
            if (e == 10) begin
                start = 1'b0; dividend = 32'd1; divisor = 32'd1;
            end
            if (done) begin
                ndone++;
                done_edge = e;
            end
        end
        chk("ign_ndone", W'(ndone), 1);
        chk("ign_edge", W'(done_edge), 35);
        chk("ign_q", quotient, 32'd14);
        chk("ign_r", remainder, 32'd2);

        // clr mid-iteration aborts without done
        @(posedge clk); #1;
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (e == 11) clr = 1'b1;
        end
        clr = 1'b0;
        chk("clr_busy", W'(busy), 0);
        chk("clr_done", W'(done), 0);
        chk("clr_q", quotient, 0);
        chk("clr_r", remainder, 0);
        ndone = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("clr_no_done", W'(ndone), 0);
        run_op(32'h00000062, 32'h00000012, q, r, dbz, lat);
        chk("clr_fresh_q", q, 32'd5);
        chk("clr_fresh_r", r, 32'h00000008);
        chk("clr_fresh_lat", W'(lat), 35);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = W'($signed($urandom_range(0, 16)) - 8);
                2: b = 32'hFFFFFFFF;
                3: begin b = $urandom; a = 32'h80000000; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(a, b, eq, er, edbz, elat);
            run_op(a, b, q, r, dbz, lat);
            chk($sformatf("rnd%0d_q a=%08h b=%08h", i, a, b), q, eq);
            chk($sformatf("rnd%0d_r a=%08h b=%08h", i, a, b), r, er);
            chk($sformatf("rnd%0d_dbz", i), W'(dbz), W'(edbz));
            chk($sformatf("rnd%0d_lat", i), W'(lat), W'(elat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
